// File: rtl/fir_seq_pkg.sv
// Shared types and sizing for the FIR start/done sequencer.
package fir_seq_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 31;
  localparam int HOLDOFF_DEF = 10;

  localparam int TO_CNT_W = $clog2(TIMEOUT_DEF + 1);
  localparam int HO_CNT_W = $clog2(HOLDOFF_DEF + 1);

  typedef enum logic [2:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_CAPTURE,
    ST_HOLD
  } seq_state_e;

endpackage

// File: rtl/seq_sync_fifo.sv
// Small synchronous FIFO; head is read straight out of the storage registers.
module seq_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fir_sample_sequencer.sv
// Feeds buffered samples to the 8-tap FIR one start at a time and returns
// each result on a valid/ready stream.
module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int HOLDOFF    = HOLDOFF_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              f_start,
  output logic [DATA_W-1:0] f_data_in,
  input  logic              f_done,
  input  logic [DATA_W-1:0] f_data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TO_W = (TIMEOUT > TIMEOUT_DEF) ? $clog2(TIMEOUT + 1) : TO_CNT_W;
  localparam int HO_W = (HOLDOFF > HOLDOFF_DEF) ? $clog2(HOLDOFF + 1) : HO_CNT_W;

  seq_state_e        state;
  seq_state_e        state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [HO_W-1:0]   ho_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              ho_done;
  logic              to_expire;

  assign s_ready   = !fifo_full;
  assign push      = s_valid && s_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign ho_done   = (ho_cnt == HO_W'(HOLDOFF - 1));
  assign to_expire = (to_cnt == TO_W'(TIMEOUT - 1));

  seq_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_HOLDOFF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLDOFF:   if (ho_done) state_nxt = ST_IDLE;
      ST_IDLE:      if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (f_done)         state_nxt = ST_CAPTURE;
        else if (to_expire) state_nxt = ST_IDLE;
      end
      ST_CAPTURE:   state_nxt = ST_HOLD;
      ST_HOLD:      if (m_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_HOLDOFF;
    endcase
  end

  always_comb begin
    f_start = (state == ST_ISSUE);
    m_valid = (state == ST_HOLD);
    busy    = (state != ST_IDLE) || !fifo_empty;
  end

  // f_data_in is held between starts because the filter shifts on every start;
  // the result is sampled in CAPTURE, one cycle after done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ho_cnt      <= '0;
      to_cnt      <= '0;
      f_data_in   <= '0;
      m_data      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_HOLDOFF && !ho_done) ho_cnt <= ho_cnt + 1'b1;
      if (state == ST_WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      else                       to_cnt <= '0;
      if (pop) f_data_in <= fifo_head;
      if (state == ST_CAPTURE) m_data <= f_data_out;
      if (state == ST_WAIT_DONE && !f_done && to_expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Scoreboard bench: a behavioural 8-tap filter stands in for the real one and
// a history-based reference predicts every result the sequencer must return.
module tb_fir_sample_sequencer;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 31;
  localparam int HOLDOFF    = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              f_start;
  logic [DATA_W-1:0] f_data_in;
  logic              f_done = 1'b0;
  logic [DATA_W-1:0] f_data_out = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              busy;
  logic              timeout_err;

  always #5 clock = ~clock;

  fir_sample_sequencer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .HOLDOFF    (HOLDOFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .f_start     (f_start),
    .f_data_in   (f_data_in),
    .f_done      (f_done),
    .f_data_out  (f_data_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  int unsigned       coef [8] = '{2, 12, 42, 71, 71, 42, 12, 2};
  int unsigned       imp  [8] = '{2, 12, 42, 71, 71, 42, 12, 2};
  logic [DATA_W-1:0] hist    [$];
  logic [DATA_W-1:0] exp_q   [$];
  logic [DATA_W-1:0] start_q [$];
  logic [DATA_W-1:0] got_q   [$];
  int                start_cnt = 0;
  bit                prev_start = 1'b0;
  bit                dead = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endfunction

  // Result of the FIR over every sample the filter has accepted so far.
  function automatic logic [DATA_W-1:0] ref_result();
    int unsigned acc = 0;
    for (int k = 0; k < 8; k++)
      if (hist.size() > k) acc += coef[k] * hist[hist.size() - 1 - k];
    return DATA_W'(acc >> 8);
  endfunction

  // Stand-in filter: done 9 cycles after start, data_out registered on done.
  logic [DATA_W-1:0] dline [8] = '{default: '0};
  logic [DATA_W-1:0] fres = '0;
  int                fcnt = 0;
  always @(posedge clock) begin
    int unsigned acc;
    f_done <= 1'b0;
    if (f_done) f_data_out <= fres;
    if (f_start && !dead) begin
      for (int k = 7; k > 0; k--) dline[k] = dline[k-1];
      dline[0] = f_data_in;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += coef[k] * dline[k];
      fres = DATA_W'(acc >> 8);
      fcnt = 9;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 1) f_done <= 1'b1;
    end
  end

  // Monitor: start pulses and result handshakes, compared against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (f_start) begin
        start_cnt++;
        check("start_one_cycle", 32'(prev_start), 0);
        check("start_while_result_pending", 32'(m_valid), 0);
        check("start_has_sample", 32'(start_q.size() != 0), 1);
        if (start_q.size() != 0) check("f_data_in", 32'(f_data_in), 32'(start_q.pop_front()));
      end
      if (m_valid && m_ready) begin
        check("result_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        got_q.push_back(m_data);
      end
    end
    prev_start = f_start;
  end

  task automatic send(input logic [DATA_W-1:0] d, input bit expect_out);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clock);
    while (!s_ready && w < 500) begin
      w++;
      @(negedge clock);
    end
    if (!s_ready) begin
      check("send_accepted", 32'(s_ready), 1);
      s_valid = 1'b0;
    end else begin
      start_q.push_back(d);
      if (expect_out) begin
        hist.push_back(d);
        exp_q.push_back(ref_result());
      end
      @(posedge clock);
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0) && w < 2000) begin
      @(negedge clock);
      w++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_f_start"},     32'(f_start), 0);
    check({tag, "_f_data_in"},   32'(f_data_in), 0);
    check({tag, "_m_valid"},     32'(m_valid), 0);
    check({tag, "_m_data"},      32'(m_data), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_s_ready"},     32'(s_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    int  w;
    int  start_cnt0;
    bit  bp_done;
    bit  rnd_done;
    bit  rs_done;

    // Power-up reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    check("reset_busy", 32'(busy), 1);

    // Holdoff: sample offered immediately on release
    @(posedge clock);
    #1 reset = 1'b0;
    fork
      send('0, 1'b1);
    join_none
    for (c = 0; c < 40; c++) begin
      @(negedge clock);
      if (f_start) break;
      if (c < HOLDOFF) check("holdoff_no_start", 32'(f_start), 0);
    end
    check("first_start_cycle", c, HOLDOFF + 1);
    wait_drain("holdoff_drain");

    // Prime, then impulse
    for (int i = 0; i < 7; i++) send('0, 1'b1);
    send(DATA_W'(256), 1'b1);
    for (int i = 0; i < 7; i++) send('0, 1'b1);
    wait_drain("impulse_drain");
    for (int k = 0; k < 8; k++)
      check("impulse_response", 32'(got_q[got_q.size() - 8 + k]), imp[k]);

    // Step of 256
    for (int i = 0; i < 8; i++) send(DATA_W'(256), 1'b1);
    wait_drain("step_drain");
    check("step_final", 32'(m_data), 254);

    // Backpressure: results blocked, FIFO fills
    m_ready    = 1'b0;
    start_cnt0 = start_cnt;
    bp_done    = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(DATA_W'($urandom_range(0, 4095)), 1'b1);
        bp_done = 1'b1;
      end
    join_none
    repeat (40) @(negedge clock);
    check("bp_s_ready_low", 32'(s_ready), 0);
    check("bp_m_valid_held", 32'(m_valid), 1);
    check("bp_single_start", start_cnt - start_cnt0, 1);
    @(posedge clock);
    #1 m_ready = 1'b1;
    w = 0;
    while (!bp_done && w < 1000) begin
      @(negedge clock);
      w++;
    end
    check("bp_sender_done", 32'(bp_done), 1);
    wait_drain("bp_drain");

    // Random samples with random downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send(DATA_W'($urandom), 1'b1);
          repeat ($urandom_range(0, 3)) @(posedge clock);
          #1;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1 m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    wait_drain("random_drain");

    // Filter never answers
    dead = 1'b1;
    send(DATA_W'($urandom), 1'b0);
    c = 0;
    while (!f_start && c < 50) begin
      @(negedge clock);
      c++;
    end
    check("timeout_start_seen", 32'(f_start), 1);
    c = 0;
    while (!timeout_err && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("timeout_latency", c, TIMEOUT + 1);
    repeat (2) @(negedge clock);
    check("timeout_back_idle", 32'(busy), 0);
    check("timeout_no_result", 32'(m_valid), 0);
    @(posedge clock);
    #1 dead = 1'b0;
    send(DATA_W'($urandom), 1'b1);
    wait_drain("after_timeout_drain");
    check("timeout_sticky", 32'(timeout_err), 1);

    // Flush filter with zeros, then reset while waiting for done
    for (int i = 0; i < 8; i++) send('0, 1'b1);
    wait_drain("flush_drain");
    rs_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send('0, 1'b1);
        rs_done = 1'b1;
      end
    join_none
    c = 0;
    while (!f_start && c < 50) begin
      @(negedge clock);
      c++;
    end
    check("midreset_start_seen", 32'(f_start), 1);
    repeat (5) @(negedge clock);
    check("midreset_sends_done", 32'(rs_done), 1);
    @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    start_q.delete();
    hist.delete();
    @(negedge clock);
    check_reset_outputs("midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("midreset_no_start", 32'(f_start), 0);
    end
    check("midreset_fifo_empty_idle", 32'(busy), 0);
    @(posedge clock);
    #1;
    send(DATA_W'($urandom), 1'b1);
    wait_drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
